stage4_accum: RTL

STAGE4_ACCUM -- requirements
Module: stage4_accum

---
 rtl/stage4_accum.sv | 97 +++++++++
 1 files changed

// File: rtl/stage4_accum.sv
// Signed dot-product accumulator stage: sums 20-bit products into an ACC_W result and holds it for a consumer.
// Define STAGE4_SAT_EN to clamp on overflow; by default an overflowing add wraps. ovf is flagged in both builds.
module stage4_accum #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic signed [19:0]      signed_sum,
  output logic                    in_ready,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0]        term_cnt,
  output logic                    ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;

  state_t                  r_state, w_state_nxt;
  logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic                    r_ovf, w_ovf_nxt;
  logic                    w_accept;
  logic signed [ACC_W-1:0] w_term_ext;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_add_ovf;
  logic signed [ACC_W-1:0] w_add_res;

  assign w_term_ext = {{(ACC_W-20){signed_sum[19]}}, signed_sum};
  // One guard bit: the two top bits disagree exactly when the ACC_W result overflowed.
  assign w_sum      = {r_acc[ACC_W-1], r_acc} + {w_term_ext[ACC_W-1], w_term_ext};
  assign w_add_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];

`ifdef STAGE4_SAT_EN
  assign w_add_res = !w_add_ovf ? w_sum[ACC_W-1:0] : (w_sum[ACC_W] ? ACC_MIN : ACC_MAX);
`else
  assign w_add_res = w_sum[ACC_W-1:0];
`endif

  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = (r_state == S_HOLD);
  assign w_accept  = in_valid && in_ready;
  assign acc_out   = (r_state == S_IDLE) ? '0 : r_acc;
  assign term_cnt  = r_cnt;
  assign ovf       = r_ovf;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_acc_nxt   = w_term_ext;
          w_cnt_nxt   = CNT_W'(1);
          w_ovf_nxt   = 1'b0;
          w_state_nxt = in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          w_acc_nxt   = w_add_res;
          w_cnt_nxt   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
          w_ovf_nxt   = r_ovf | w_add_ovf;
          w_state_nxt = in_last ? S_HOLD : S_ACCUM;
        end
      end
      S_HOLD: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

endmodule
